// File: rtl/dcm_clk_div.sv
// Clock manager: fixed divide clk_1, programmable 2^(P+1) divide clk_2; outputs registered, settings apply at clk_2 half-period boundaries.
// Optional `DCM_LOCKED_EN adds a locked flag that rises at the first clk_2 rise after the latest setting took effect.
module dcm_clk_div #(
  parameter int unsigned CLK1_DIV   = 2,
  parameter logic [2:0]  PROG_RESET = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [2:0] prog_in,
  output logic [2:0] prog_out,
  output logic       clk_1,
  output logic       clk_2
`ifdef DCM_LOCKED_EN
  ,
  output logic       locked
`endif
);

  localparam int unsigned HALF1 = CLK1_DIV / 2;
  localparam int unsigned C1W   = (HALF1 > 1) ? $clog2(HALF1) : 1;
  localparam logic [C1W-1:0] C1_TC = C1W'(HALF1 - 1);

  logic [C1W-1:0] r_cnt1;
  logic           r_clk1;
  logic [6:0]     r_cnt2;
  logic           r_clk2;
  logic [2:0]     r_active;
  logic [2:0]     r_pending;
  logic           r_pend_vld;

  logic [7:0]     w_half;
  logic [6:0]     w_tc;
  logic           w_bnd;
  logic           w_apply;
  logic [2:0]     w_next_act;

  // Half-period of 128 wraps the 7-bit terminal count to 127 as intended.
  assign w_half     = 8'd1 << r_active;
  assign w_tc       = 7'(w_half - 8'd1);
  assign w_bnd      = (r_cnt2 == w_tc);
  assign w_apply    = w_bnd & (update | r_pend_vld);
  assign w_next_act = update ? prog_in : r_pending;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt1     <= '0;
      r_clk1     <= 1'b0;
      r_cnt2     <= '0;
      r_clk2     <= 1'b0;
      r_active   <= PROG_RESET;
      r_pending  <= PROG_RESET;
      r_pend_vld <= 1'b0;
    end else begin
      if (r_cnt1 == C1_TC) begin
        r_cnt1 <= '0;
        r_clk1 <= ~r_clk1;
      end else begin
        r_cnt1 <= r_cnt1 + C1W'(1);
      end

      if (w_bnd) begin
        r_cnt2 <= '0;
        r_clk2 <= ~r_clk2;
      end else begin
        r_cnt2 <= r_cnt2 + 7'd1;
      end

      // A same-edge update bypasses the pending register straight into active.
      if (w_apply) begin
        r_active   <= w_next_act;
        r_pend_vld <= 1'b0;
      end else if (update) begin
        r_pending  <= prog_in;
        r_pend_vld <= 1'b1;
      end
    end
  end

`ifdef DCM_LOCKED_EN
  logic r_locked;

  always_ff @(posedge clk) begin
    if (!rst || update) begin
      r_locked <= 1'b0;
    end else if (w_bnd && !r_clk2) begin
      r_locked <= 1'b1;
    end
  end

  assign locked = r_locked;
`endif

  assign prog_out = r_active;
  assign clk_1    = r_clk1;
  assign clk_2    = r_clk2;

endmodule

// File: tb/tb_dcm_clk_div.sv
// Randomised bench for dcm_clk_div against a phase-duration reference model.
module tb_dcm_clk_div;

  localparam int unsigned CLK1_DIV   = 2;
  localparam logic [2:0]  PROG_RESET = 3'd0;
  localparam int          HALF1      = CLK1_DIV / 2;

  logic       clk;
  logic       rst;
  logic       update;
  logic [2:0] prog_in;
  logic [2:0] prog_out;
  logic       clk_1;
  logic       clk_2;
`ifdef DCM_LOCKED_EN
  logic       locked;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining cycles in the current phase of each output.
  int m_c1_left, m_c2_left, m_act, m_pend;
  bit m_clk1, m_clk2, m_pv, m_lock;
  int ph_len, ph_exp;
  bit ph_prev;

  dcm_clk_div #(.CLK1_DIV(CLK1_DIV), .PROG_RESET(PROG_RESET)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .prog_in  (prog_in),
    .prog_out (prog_out),
    .clk_1    (clk_1),
    .clk_2    (clk_2)
`ifdef DCM_LOCKED_EN
    ,
    .locked   (locked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit u, input int p);
    if (!r) begin
      m_clk1    = 0;
      m_c1_left = HALF1;
      m_clk2    = 0;
      m_act     = PROG_RESET;
      m_c2_left = 1 << m_act;
      m_pv      = 0;
      m_lock    = 0;
    end else begin
      if (m_c1_left == 1) begin
        m_clk1    = ~m_clk1;
        m_c1_left = HALF1;
      end else begin
        m_c1_left--;
      end
      if (m_c2_left == 1) begin
        m_clk2 = ~m_clk2;
        if (u)         m_act = p;
        else if (m_pv) m_act = m_pend;
        m_pv      = 0;
        m_c2_left = 1 << m_act;
        if (m_clk2) m_lock = 1;
      end else begin
        m_c2_left--;
        if (u) begin
          m_pend = p;
          m_pv   = 1;
        end
      end
      if (u) m_lock = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit u, input logic [2:0] p);
    rst     = r;
    update  = u;
    prog_in = p;
    @(posedge clk);
    model_step(r, u, int'(p));
    #1;
    chk("clk_1", clk_1, m_clk1);
    chk("clk_2", clk_2, m_clk2);
    chk("prog_out", prog_out, m_act);
`ifdef DCM_LOCKED_EN
    chk("locked", locked, m_lock);
`endif
    // Every clk_2 phase must last exactly the half-period in force when it began.
    if (!r) begin
      ph_len  = 0;
      ph_exp  = 1 << m_act;
      ph_prev = 0;
    end else begin
      ph_len++;
      if (clk_2 !== ph_prev) begin
        chk("phase_len", ph_len, ph_exp);
        ph_len  = 0;
        ph_exp  = 1 << m_act;
        ph_prev = clk_2;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 3'd0);
  endtask

  initial begin
    rst = 1'b0; update = 1'b0; prog_in = 3'd0;

    cyc(0, 1, 3'd6);
    cyc(0, 0, 3'd0);
    chk("rst_clk1", clk_1, 0);
    chk("rst_clk2", clk_2, 0);
    chk("rst_prog", prog_out, PROG_RESET);
    run(20);

    cyc(1, 1, 3'd2);
    run(40);
    chk("prog2", prog_out, 2);

    cyc(1, 1, 3'd5);
    run(180);
    cyc(1, 1, 3'd7);
    run(600);

    // Align to the start of a 128-cycle half, then load 0 thirty cycles in.
    for (int i = 0; i < 300; i++) begin
      if (m_act == 7 && m_c2_left == 128) break;
      cyc(1, 0, 3'd0);
    end
    run(29);
    cyc(1, 1, 3'd0);
    chk("hold_prog7", prog_out, 7);
    run(120);
    chk("prog0", prog_out, 0);

    cyc(1, 1, 3'd2);
    run(10);
    for (int i = 0; i < 8; i++) begin
      if (m_c2_left == 4) break;
      cyc(1, 0, 3'd0);
    end
    cyc(1, 1, 3'd3);
    cyc(1, 1, 3'd6);
    run(20);
    chk("last_wins", prog_out, 6);

    for (int i = 0; i < 200; i++) begin
      if (m_c2_left == 1) break;
      cyc(1, 0, 3'd0);
    end
    cyc(1, 1, 3'd1);
    chk("bypass", prog_out, 1);
    run(8);

    cyc(1, 1, 3'd5);
    run(70);
    cyc(1, 1, 3'd4);
    run(3);
    cyc(0, 0, 3'd0);
    chk("mid_rst_clk2", clk_2, 0);
    chk("mid_rst_prog", prog_out, PROG_RESET);
    run(80);
    chk("pend_dropped", prog_out, PROG_RESET);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
          3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
